roughness_frame_stats: RTL and testbench

//  Frame-statistics stage fed by the roughness feature path; consumes the down-sampled,

---
 rtl/roughness_frame_stats.sv | 137 +++++++++++++
 tb/tb_roughness_frame_stats.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/roughness_frame_stats.sv
// roughness_frame_stats
//   Frame-statistics stage for the down-sampled roughness stream. One sample is
//   captured per rising edge of ds_clk (after synchronising it into clk).
//   2**LOG2_FRAME samples make up a frame. Each finished frame produces the
//   signed mean and the saturated peak |x|. The result is offered through a
//   one-entry valid/ready slot.
//
// Ports
//   clk          system clock
//   reset        asynchronous, active-high reset
//   enable       1 = accumulate, 0 = discard the partial frame and ignore edges
//   ds_clk       down-sample clock, asynchronous to clk
//   rough_in     signed roughness sample, valid while ds_clk is high
//   frame_mean   signed frame mean (floor of sum / 2**LOG2_FRAME)
//   frame_peak   max |sample| in the frame, unsigned, saturated
//   frame_valid  output slot holds an unconsumed result
//   frame_ready  consumer accepts when frame_valid & frame_ready
//   overrun      sticky flag: a finished frame was dropped
//   clr_overrun  synchronous clear of overrun (a simultaneous set wins)
//   fill_count   samples captured so far in the current frame

module roughness_frame_stats #(
  parameter int DATA_W     = 16,
  parameter int LOG2_FRAME = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  ds_clk,
  input  logic [DATA_W-1:0]     rough_in,
  output logic [DATA_W-1:0]     frame_mean,
  output logic [DATA_W-1:0]     frame_peak,
  output logic                  frame_valid,
  input  logic                  frame_ready,
  output logic                  overrun,
  input  logic                  clr_overrun,
  output logic [LOG2_FRAME-1:0] fill_count
);

  localparam int ACC_W = DATA_W + LOG2_FRAME;
  localparam logic [DATA_W-1:0]     S_MIN = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0]     S_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [LOG2_FRAME-1:0] LAST  = '1;

  logic                    sync_q0, sync_q1, sync_q2;
  logic                    ds_rise, cap, last_sample, frame_done, slot_free;
  logic signed [ACC_W-1:0] acc, sample_ext, sum;
  logic [DATA_W-1:0]       peak_acc, abs_x, pk, mean_next;

  // sync_q0/sync_q1 form the synchroniser; sync_q2 is the edge-detect delay.
  // The sample is therefore taken on the third clk edge after ds_clk rises.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q0 <= 1'b0;
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
    end else begin
      sync_q0 <= ds_clk;
      sync_q1 <= sync_q0;
      sync_q2 <= sync_q1;
    end
  end

  // The most negative input has no positive twin, so its magnitude saturates.
  // The mean is the upper DATA_W bits of the sum. This equals an arithmetic
  // shift right by LOG2_FRAME, which rounds toward minus infinity.
  always_comb begin
    ds_rise     = sync_q1 & ~sync_q2;
    cap         = ds_rise & enable;
    last_sample = (fill_count == LAST);
    frame_done  = cap & last_sample;
    slot_free   = ~frame_valid | frame_ready;
    sample_ext  = {{LOG2_FRAME{rough_in[DATA_W-1]}}, rough_in};
    sum         = acc + sample_ext;
    mean_next   = sum[LOG2_FRAME +: DATA_W];
    if (rough_in == S_MIN) begin
      abs_x = S_MAX;
    end else if (rough_in[DATA_W-1]) begin
      abs_x = -rough_in;
    end else begin
      abs_x = rough_in;
    end
    pk = (abs_x > peak_acc) ? abs_x : peak_acc;
  end

  // Frame accumulation. The last sample clears the state on the same edge,
  // so the next frame starts without a dead cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      peak_acc   <= '0;
      fill_count <= '0;
    end else if (!enable) begin
      acc        <= '0;
      peak_acc   <= '0;
      fill_count <= '0;
    end else if (cap) begin
      if (last_sample) begin
        acc        <= '0;
        peak_acc   <= '0;
        fill_count <= '0;
      end else begin
        acc        <= sum;
        peak_acc   <= pk;
        fill_count <= fill_count + 1'b1;
      end
    end
  end

  // One-entry output slot. A new result may replace a result that is being
  // accepted on the same edge. If the slot is still held, the new result is
  // dropped and the event is recorded in overrun.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_mean  <= '0;
      frame_peak  <= '0;
      frame_valid <= 1'b0;
    end else if (frame_done && slot_free) begin
      frame_mean  <= mean_next;
      frame_peak  <= pk;
      frame_valid <= 1'b1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overrun <= 1'b0;
    end else if (frame_done && !slot_free) begin
      overrun <= 1'b1;
    end else if (clr_overrun) begin
      overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_roughness_frame_stats.sv
// tb_roughness_frame_stats
//   Directed bench for roughness_frame_stats (DATA_W=16, LOG2_FRAME=6).
//   Each ds_clk pulse is driven from the falling edge of clk. A small monitor
//   records every accepted result so the bench can check handshakes that last
//   only one cycle.

module tb_roughness_frame_stats;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic        ds_clk;
  logic [15:0] rough_in;
  logic [15:0] frame_mean;
  logic [15:0] frame_peak;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
  logic        clr_overrun;
  logic [5:0]  fill_count;

  int          checks = 0;
  int          errors = 0;
  int          acc_count = 0;
  int          exp_count = 0;
  logic [15:0] last_mean = '0;
  logic [15:0] last_peak = '0;

  roughness_frame_stats #(.DATA_W(16), .LOG2_FRAME(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .ds_clk      (ds_clk),
    .rough_in    (rough_in),
    .frame_mean  (frame_mean),
    .frame_peak  (frame_peak),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .overrun     (overrun),
    .clr_overrun (clr_overrun),
    .fill_count  (fill_count)
  );

  always #5 clk = ~clk;

  // The monitor samples mid-cycle, after the stimulus has settled on the falling edge.
  always begin
    @(negedge clk);
    #1;
    if (frame_valid === 1'b1 && frame_ready === 1'b1) begin
      acc_count++;
      last_mean = frame_mean;
      last_peak = frame_peak;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One ds_clk pulse. The task is called and returns on a falling edge of clk.
  task automatic apply_stimulus(input logic [15:0] v, input int high_cycles);
    rough_in = v;
    ds_clk   = 1'b1;
    repeat (high_cycles) @(negedge clk);
    ds_clk   = 1'b0;
    rough_in = '0;
    repeat (3) @(negedge clk);
  endtask

  task automatic feed_const(input logic [15:0] v, input int n);
    for (int i = 0; i < n; i++) apply_stimulus(v, 5);
  endtask

  initial begin
    reset       = 1'b1;
    enable      = 1'b0;
    ds_clk      = 1'b0;
    rough_in    = '0;
    frame_ready = 1'b0;
    clr_overrun = 1'b0;
    repeat (3) @(negedge clk);
    check_output("reset_mean",  frame_mean,  16'h0);
    check_output("reset_peak",  frame_peak,  16'h0);
    check_output("reset_valid", frame_valid, 1'b0);
    check_output("reset_ovr",   overrun,     1'b0);
    check_output("reset_fill",  fill_count,  6'd0);
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] test 1: constant 100");
    enable      = 1'b1;
    frame_ready = 1'b1;
    feed_const(16'd100, 63);
    check_output("t1_fill63", fill_count, 6'd63);
    check_output("t1_novalid", acc_count, exp_count);
    feed_const(16'd100, 1);
    exp_count++;
    check_output("t1_count", acc_count, exp_count);
    check_output("t1_mean",  last_mean, 16'd100);
    check_output("t1_peak",  last_peak, 16'd100);
    check_output("t1_fill0", fill_count, 6'd0);
    check_output("t1_valid", frame_valid, 1'b0);

    $display("[TB] test 2: negative extremes");
    feed_const(16'hFFFF, 64);
    exp_count++;
    check_output("t2a_count", acc_count, exp_count);
    check_output("t2a_mean",  last_mean, 16'hFFFF);
    check_output("t2a_peak",  last_peak, 16'd1);
    feed_const(16'h8000, 64);
    exp_count++;
    check_output("t2b_count", acc_count, exp_count);
    check_output("t2b_mean",  last_mean, 16'h8000);
    check_output("t2b_peak",  last_peak, 16'h7FFF);

    $display("[TB] test 3: ramp and alternating");
    for (int i = 0; i < 64; i++) apply_stimulus(16'(i), 5);
    exp_count++;
    check_output("t3a_count", acc_count, exp_count);
    check_output("t3a_mean",  last_mean, 16'd31);
    check_output("t3a_peak",  last_peak, 16'd63);
    for (int i = 0; i < 32; i++) begin
      apply_stimulus(16'd5, 5);
      apply_stimulus(16'hFFFA, 5);
    end
    exp_count++;
    check_output("t3b_count", acc_count, exp_count);
    check_output("t3b_mean",  last_mean, 16'hFFFF);
    check_output("t3b_peak",  last_peak, 16'd6);

    $display("[TB] test 4: held slot and overrun");
    frame_ready = 1'b0;
    feed_const(16'd10, 64);
    check_output("t4_valid1", frame_valid, 1'b1);
    check_output("t4_mean1",  frame_mean,  16'd10);
    check_output("t4_peak1",  frame_peak,  16'd10);
    check_output("t4_ovr0",   overrun,     1'b0);
    feed_const(16'd20, 64);
    check_output("t4_valid2", frame_valid, 1'b1);
    check_output("t4_mean2",  frame_mean,  16'd10);
    check_output("t4_ovr1",   overrun,     1'b1);
    frame_ready = 1'b1;
    @(negedge clk);
    exp_count++;
    check_output("t4_vdrop",  frame_valid, 1'b0);
    check_output("t4_count",  acc_count,   exp_count);
    check_output("t4_accm",   last_mean,   16'd10);
    check_output("t4_sticky", overrun,     1'b1);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check_output("t4_clr",    overrun,     1'b0);

    $display("[TB] test 5: enable drop and reset mid-frame");
    feed_const(16'd50, 30);
    check_output("t5_fill30", fill_count, 6'd30);
    enable = 1'b0;
    @(negedge clk);
    check_output("t5_fill0", fill_count, 6'd0);
    feed_const(16'd99, 2);
    check_output("t5_ignored", fill_count, 6'd0);
    enable = 1'b1;
    feed_const(16'd7, 64);
    exp_count++;
    check_output("t5_count", acc_count, exp_count);
    check_output("t5_mean",  last_mean, 16'd7);
    check_output("t5_peak",  last_peak, 16'd7);
    feed_const(16'd3, 40);
    check_output("t5_fill40", fill_count, 6'd40);
    reset = 1'b1;
    @(negedge clk);
    check_output("t5_rst_mean",  frame_mean,  16'h0);
    check_output("t5_rst_peak",  frame_peak,  16'h0);
    check_output("t5_rst_valid", frame_valid, 1'b0);
    check_output("t5_rst_fill",  fill_count,  6'd0);
    reset = 1'b0;
    @(negedge clk);
    feed_const(16'd9, 63);
    check_output("t5_nofrm", acc_count, exp_count);
    check_output("t5_fill63", fill_count, 6'd63);
    feed_const(16'd9, 1);
    exp_count++;
    check_output("t5_count2", acc_count, exp_count);
    check_output("t5_mean2",  last_mean, 16'd9);

    $display("[TB] test 6: accept and load on the same edge");
    frame_ready = 1'b0;
    feed_const(16'd11, 64);
    check_output("t6_mean11", frame_mean, 16'd11);
    feed_const(16'd22, 63);
    rough_in = 16'd22;
    ds_clk   = 1'b1;
    @(negedge clk);
    @(negedge clk);
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
    exp_count++;
    check_output("t6_valid",  frame_valid, 1'b1);
    check_output("t6_mean22", frame_mean,  16'd22);
    check_output("t6_ovr",    overrun,     1'b0);
    check_output("t6_acc11",  last_mean,   16'd11);
    repeat (2) @(negedge clk);
    ds_clk   = 1'b0;
    rough_in = '0;
    repeat (3) @(negedge clk);
    frame_ready = 1'b1;
    repeat (2) @(negedge clk);
    exp_count++;
    check_output("t6_count", acc_count, exp_count);
    check_output("t6_acc22", last_mean, 16'd22);
    apply_stimulus(16'd4, 20);
    check_output("t6_onecap", fill_count, 6'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
